// File: rtl/mem_bus_port_pkg.sv
// Shared definitions for the cache-line bus port: FSM state encoding,
// bus opcodes and default geometry.
package mem_bus_port_pkg;

  localparam int DEF_BUS_DATA_WIDTH = 64;
  localparam int DEF_BEATS          = 8;

  localparam logic [3:0] OP_IDLE  = 4'h0;
  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_bus_port_beat_counter.sv
// Beat index for one line transfer; saturates on the final beat so it never
// wraps back to slot 0 while the FSM is leaving the data phase.
module beat_counter
  import mem_bus_port_pkg::*;
#(
  parameter int BEATS = DEF_BEATS,
  parameter int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q, count_d;

  assign count = count_q;
  assign last  = (count_q == CW'(BEATS - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_port.sv
// Single-outstanding cache-line port: arbitrates for the bus, sends an address
// beat, then streams write beats out or collects read beats into a line.
module mem_bus_port
  import mem_bus_port_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
  parameter int BEATS          = DEF_BEATS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [63:0]                     req_addr,
  input  logic [BUS_DATA_WIDTH*BEATS-1:0] req_wdata,
  output logic                            resp_valid,
  output logic [BUS_DATA_WIDTH*BEATS-1:0] resp_rdata,
  output logic                            bus_reqcyc,
  input  logic                            bus_grant,
  output logic                            bus_busy,
  output logic [63:0]                     bus_req,
  output logic [3:0]                      bus_reqtag,
  input  logic                            bus_respcyc,
  input  logic [63:0]                     bus_resp,
  output logic                            bus_respack
);

  localparam int          LINE_W    = BUS_DATA_WIDTH * BEATS;
  localparam int          CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int          OFS_W     = $clog2(BEATS * 8);
  localparam logic [63:0] ADDR_MASK = ~((64'd1 << OFS_W) - 64'd1);

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [63:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;

  logic [BUS_DATA_WIDTH-1:0] wbeat [BEATS];
  logic [BUS_DATA_WIDTH-1:0] rbeat_q [BEATS];
  logic [BUS_DATA_WIDTH-1:0] rbeat_d;
  logic [BEATS-1:0]          rbeat_we;

  logic [CW-1:0] beat_cnt;
  logic          beat_last;
  logic          cnt_clear;
  logic          cnt_en;
  logic          accept;

  assign req_ready   = (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign bus_reqcyc  = (state_q == ST_ARB);
  assign bus_busy    = (state_q == ST_ADDR) || (state_q == ST_WDATA) || (state_q == ST_RDATA);
  assign bus_respack = (state_q == ST_RDATA) && bus_respcyc;
  assign resp_valid  = (state_q == ST_DONE);

  assign cnt_clear = (state_q == ST_ADDR);
  assign cnt_en    = (state_q == ST_WDATA) || bus_respack;
  assign rbeat_d   = BUS_DATA_WIDTH'(bus_resp);

  beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (beat_cnt),
    .last   (beat_last)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr & ADDR_MASK;
          wline_d = req_wdata;
          state_d = ST_ARB;
        end
      end
      // Only a grant seen while already requesting counts.
      ST_ARB:   if (bus_grant) state_d = ST_ADDR;
      ST_ADDR:  state_d = write_q ? ST_WDATA : ST_RDATA;
      ST_WDATA: if (beat_last) state_d = ST_DONE;
      ST_RDATA: if (bus_respcyc && beat_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req    = '0;
    bus_reqtag = OP_IDLE;
    if (state_q == ST_ADDR) begin
      bus_req    = addr_q;
      bus_reqtag = write_q ? OP_WRITE : OP_READ;
    end else if (state_q == ST_WDATA) begin
      bus_req    = 64'(wbeat[beat_cnt]);
      bus_reqtag = OP_WRITE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
    end
  end

  // Read slots keep their contents across writes so resp_rdata holds the last read line.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    assign wbeat[gi]    = wline_q[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    assign rbeat_we[gi] = bus_respack && (beat_cnt == CW'(gi));
    assign resp_rdata[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = rbeat_q[gi];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rbeat_q[gi] <= '0;
      end else if (rbeat_we[gi]) begin
        rbeat_q[gi] <= rbeat_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_port.sv
// Directed bench for mem_bus_port: read, write, gapped read, reset abort,
// withheld grant and stray response beats.
module tb_mem_bus_port;

  localparam int W  = 64;
  localparam int B  = 8;
  localparam int LW = W * B;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [63:0]   req_addr;
  logic [LW-1:0] req_wdata;
  logic          resp_valid;
  logic [LW-1:0] resp_rdata;
  logic          bus_reqcyc;
  logic          bus_grant;
  logic          bus_busy;
  logic [63:0]   bus_req;
  logic [3:0]    bus_reqtag;
  logic          bus_respcyc;
  logic [63:0]   bus_resp;
  logic          bus_respack;

  int checks   = 0;
  int failures = 0;

  mem_bus_port #(
    .BUS_DATA_WIDTH (W),
    .BEATS          (B)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .bus_reqcyc  (bus_reqcyc),
    .bus_grant   (bus_grant),
    .bus_busy    (bus_busy),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_respack (bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkline(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] make_line(input logic [63:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < B; k++) l[k*W +: W] = base + 64'(k);
    return l;
  endfunction

  task automatic accept(input logic wr, input logic [63:0] addr, input logic [LW-1:0] wd,
                        input logic gnt);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    bus_grant = gnt;
    #1;
    chk1("accept_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  // Called right after entering RDATA; returns at the start of the DONE cycle.
  task automatic read_beats(input string tag, input logic [63:0] base, input int gap_at);
    for (int k = 0; k < B; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < 2; g++) begin
          bus_respcyc = 1'b0;
          #1;
          chk1({tag, "_gap_respack"}, bus_respack, 1'b0);
          chk1({tag, "_gap_busy"}, bus_busy, 1'b1);
          tick();
        end
      end
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'(k);
      #1;
      chk1({tag, "_respack"}, bus_respack, 1'b1);
      chk1({tag, "_rbusy"}, bus_busy, 1'b1);
      chk64({tag, "_rdata_busreq"}, bus_req, 64'h0);
      chk1({tag, "_rdata_respvalid"}, resp_valid, 1'b0);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    bus_grant   = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    #1;
    chk1("rst_ready", req_ready, 1'b1);
    chk1("rst_reqcyc", bus_reqcyc, 1'b0);
    chk1("rst_busy", bus_busy, 1'b0);
    chk1("rst_respack", bus_respack, 1'b0);
    chk1("rst_respvalid", resp_valid, 1'b0);
    chk64("rst_busreq", bus_req, 64'h0);
    chk64("rst_tag", {60'h0, bus_reqtag}, 64'h0);
    chkline("rst_rdata", resp_rdata, '0);
    tick();
    tick();
    reset = 1'b0;

    // Stray response beat while idle
    bus_respcyc = 1'b1;
    bus_resp    = 64'hDEAD;
    #1;
    chk1("stray_respack", bus_respack, 1'b0);
    tick();
    chk1("stray_ready", req_ready, 1'b1);
    chk1("stray_busy", bus_busy, 1'b0);
    chk1("stray_reqcyc", bus_reqcyc, 1'b0);
    bus_respcyc = 1'b0;
    bus_resp    = '0;

    // Read, grant in the acceptance cycle must be ignored, real grant after 3 ARB cycles
    accept(1'b0, 64'h1000_0040, '0, 1'b1);
    bus_grant = 1'b0;
    #1;
    chk1("rd_arb_reqcyc", bus_reqcyc, 1'b1);
    chk1("rd_arb_ready", req_ready, 1'b0);
    chk1("rd_arb_busy", bus_busy, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rd_arb_hold_reqcyc", bus_reqcyc, 1'b1);
      chk1("rd_arb_hold_busy", bus_busy, 1'b0);
    end
    bus_grant = 1'b1;
    tick();
    bus_grant   = 1'b0;
    bus_respcyc = 1'b1;
    bus_resp    = 64'hFF;
    #1;
    chk1("rd_addr_reqcyc", bus_reqcyc, 1'b0);
    chk1("rd_addr_busy", bus_busy, 1'b1);
    chk64("rd_addr_busreq", bus_req, 64'h1000_0040);
    chk64("rd_addr_tag", {60'h0, bus_reqtag}, 64'h1);
    chk1("rd_addr_respack", bus_respack, 1'b0);
    tick();
    read_beats("rd", 64'hA0, -1);
    #1;
    chk1("rd_done_respvalid", resp_valid, 1'b1);
    chkline("rd_done_rdata", resp_rdata, make_line(64'hA0));
    chk1("rd_done_busy", bus_busy, 1'b0);
    chk1("rd_done_ready", req_ready, 1'b0);
    tick();
    chk1("rd_after_respvalid", resp_valid, 1'b0);
    chk1("rd_after_ready", req_ready, 1'b1);

    // Write with immediate grant; resp_valid 11 cycles after acceptance
    accept(1'b1, 64'h2000, make_line(64'hB0), 1'b1);
    #1;
    chk1("wr_arb_reqcyc", bus_reqcyc, 1'b1);
    chk1("wr_arb_ready", req_ready, 1'b0);
    tick();
    bus_grant = 1'b0;
    chk64("wr_addr_busreq", bus_req, 64'h2000);
    chk64("wr_addr_tag", {60'h0, bus_reqtag}, 64'h2);
    chk1("wr_addr_busy", bus_busy, 1'b1);
    chk1("wr_addr_reqcyc", bus_reqcyc, 1'b0);
    for (int k = 0; k < B; k++) begin
      tick();
      chk64("wr_beat_busreq", bus_req, 64'hB0 + 64'(k));
      chk64("wr_beat_tag", {60'h0, bus_reqtag}, 64'h2);
      chk1("wr_beat_busy", bus_busy, 1'b1);
      chk1("wr_beat_respvalid", resp_valid, 1'b0);
    end
    tick();
    chk1("wr_done_respvalid", resp_valid, 1'b1);
    chkline("wr_done_rdata_hold", resp_rdata, make_line(64'hA0));
    chk64("wr_done_busreq", bus_req, 64'h0);
    chk64("wr_done_tag", {60'h0, bus_reqtag}, 64'h0);
    chk1("wr_done_busy", bus_busy, 1'b0);
    tick();
    chk1("wr_after_respvalid", resp_valid, 1'b0);
    chk1("wr_after_ready", req_ready, 1'b1);

    // Gapped read; unaligned address must be presented line-aligned
    accept(1'b0, 64'h3000_007F, '0, 1'b1);
    tick();
    bus_grant = 1'b0;
    chk64("gap_addr_busreq", bus_req, 64'h3000_0040);
    chk64("gap_addr_tag", {60'h0, bus_reqtag}, 64'h1);
    tick();
    read_beats("gap", 64'hC0, 4);
    #1;
    chk1("gap_done_respvalid", resp_valid, 1'b1);
    chkline("gap_done_rdata", resp_rdata, make_line(64'hC0));
    tick();

    // Reset during write beat 4
    accept(1'b1, 64'h4000, make_line(64'hD0), 1'b1);
    tick();
    bus_grant = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk64("rstwr_beat_busreq", bus_req, 64'hD0 + 64'(k));
      tick();
    end
    #1;
    chk64("rstwr_beat4_busreq", bus_req, 64'hD4);
    reset = 1'b1;
    #1;
    chk1("rstwr_reqcyc", bus_reqcyc, 1'b0);
    chk1("rstwr_busy", bus_busy, 1'b0);
    chk1("rstwr_respack", bus_respack, 1'b0);
    chk64("rstwr_busreq", bus_req, 64'h0);
    chk64("rstwr_tag", {60'h0, bus_reqtag}, 64'h0);
    chk1("rstwr_ready", req_ready, 1'b1);
    chk1("rstwr_respvalid", resp_valid, 1'b0);
    chkline("rstwr_rdata", resp_rdata, '0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk1("rstwr_post_respvalid", resp_valid, 1'b0);
      chk1("rstwr_post_ready", req_ready, 1'b1);
      chk1("rstwr_post_busy", bus_busy, 1'b0);
      tick();
    end

    // Grant withheld for 20 cycles
    accept(1'b0, 64'h5000, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk1("nogr_reqcyc", bus_reqcyc, 1'b1);
      chk1("nogr_busy", bus_busy, 1'b0);
      chk64("nogr_busreq", bus_req, 64'h0);
      chk64("nogr_tag", {60'h0, bus_reqtag}, 64'h0);
      tick();
    end
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    #1;
    chk64("nogr_addr_busreq", bus_req, 64'h5000);
    chk64("nogr_addr_tag", {60'h0, bus_reqtag}, 64'h1);
    tick();
    read_beats("nogr", 64'hE0, -1);
    #1;
    chk1("nogr_done_respvalid", resp_valid, 1'b1);
    chkline("nogr_done_rdata", resp_rdata, make_line(64'hE0));
    tick();
    chk1("nogr_after_ready", req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
